seven_seg_scanner: RTL
======================

# seven_seg_scanner

Time-multiplexed driver for an N-digit common-anode seven-segment display. It latches a packed nibble-per-digit value, scans the digits with a programmable per-digit slot length and an anti-ghosting blank interval, and decodes each nibble to active-low cathodes, including hex A–F and per-digit decimal points. It sits between the counter/datapath logic and the board's anode/cathode pins. It supersedes single-digit combinational decoding in the display path.

## Interface
- N_DIGITS, 4, number of digits scanned (≥2)
- TICK_DIV, 100000, clock cycles per digit slot (≥4)
- BLANK_CYCLES, 16, cycles at slot start with all anodes off (1 ≤ BLANK_CYCLES < TICK_DIV)
- HEX, 1, 1: codes 10–15 show A,b,C,d,E,F; 0: codes 10–15 show blank
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- digits_in  in  4*N_DIGITS  packed nibbles, digit 0 = bits [3:0] (rightmost)
- dp_in  in  N_DIGITS  decimal point request per digit, 1 = lit
- load  in  1  single-cycle strobe, captures digits_in/dp_in
- anode  out  N_DIGITS  active-low digit enables
- cathode  out  8  active-low segments, [7]=dp, [6:0]=g..a
- frame_done  out  1  one-cycle pulse when a new frame (digit 0 slot) starts

## Operation
- Registers: slot counter cnt (0..TICK_DIV-1), scan index idx (0..N_DIGITS-1), pending shadow (digits, dp, pend flag), active display register.
- Slot: cnt < BLANK_CYCLES → BLANK (anode all 1, cathode 8'hFF); otherwise SHOW (anode[idx]=0, others 1, cathode = decode(active nibble idx, dp idx)).
- At cnt==TICK_DIV-1: cnt→0, idx→idx+1, wrap N_DIGITS-1→0.
- Frame boundary = wrap to idx 0. At the boundary, active ← (load ? inputs : shadow) if load or pend; pend cleared; frame_done=1 for that cycle.
- load outside the boundary: shadow ← inputs, pend ← 1; repeated loads overwrite, last one wins. The active register never changes mid-frame (no tearing).
- Decode g..a (cathode[6:0]):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110 (HEX=1); blank=1111111 (HEX=0).
- cathode[7] = ~dp.

## Timing
- Reset values: anode all 1, cathode 8'hFF, frame_done 0, cnt 0, idx 0, shadow/active 0, pend 0.
- anode/cathode are registered: pins reflect the (cnt, idx) state of the previous cycle. A slot at the pins is BLANK_CYCLES blank cycles followed by TICK_DIV-BLANK_CYCLES digit cycles.
- First edge after reset release starts the digit-0 blank interval. frame_done does not pulse for this first frame. It pulses every N_DIGITS*TICK_DIV cycles thereafter.
- Load-to-display latency: from the next frame boundary plus one cycle, at most N_DIGITS*TICK_DIV+1 cycles.
- Reset mid-frame: all outputs return to reset values immediately (asynchronously), and pending data is discarded.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - At commit, a registered mask blanks (cathode 8'hFF during SHOW) every digit from N_DIGITS-1 downward whose nibble is 0 and dp is 0.
  - Blanking stops at the first digit that is nonzero or has dp set.
  - Digit 0 is never blanked.
  - The anode still asserts for a blanked digit.
- Not defined: all digits are always decoded; no mask logic is present.

## Structure
- Shared package seven_seg_pkg: SEG_* active-low 7-bit pattern constants (0–F, BLANK) and a scan-state enum (BLANK, SHOW).
- One sub-module, seg_hex_decoder: combinational nibble + dp + HEX → 8-bit active-low cathode. The scanner instantiates one copy on the muxed nibble.

## Test plan
Parameters for all tests: N_DIGITS=4, TICK_DIV=8, BLANK_CYCLES=2.
- Reset held, then released: anode=4'b1111, cathode=8'hFF. Two cycles later anode=4'b1110 with cathode=8'hC0 (0) for 6 cycles.
- load digits_in=16'h1239, dp_in=4'b0100 mid-frame → display unchanged until frame_done. The next frame shows:
  - digit 0 = 8'h90 (9, checks the 9 pattern)
  - digit 1 = 8'hB0
  - digit 2 = 8'h24 (2 with dp)
  - digit 3 = 8'hF9
- Two loads in one frame (16'h1111, then 16'h2222) → only 2222 is displayed. load on the exact boundary cycle with 16'hABCD and HEX=1 → digits d, C, b, A (8'hA1, 8'hC6, 8'h83, 8'h88) appear in that same frame.
- HEX=0, digits_in=16'hF0F0 → digits 1 and 3 show cathode 8'hFF while their anodes are active.
- LEADING_ZERO_BLANK_EN defined:
  - 16'h0050 → digits 3 and 2 blank, 5 and 0 shown.
  - 16'h0000 → only digit 0 shows 0.
  - dp_in=4'b0100 with 16'h0005 → digit 2 shows 8'h40 (0 with dp); digit 3 blank.
- rst asserted during a digit-2 SHOW cycle → anode=4'b1111, cathode=8'hFF in the same cycle. After release, scanning restarts at digit 0 with active value 0.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment display path: active-low g..a
// segment patterns and the per-slot scan state.
package seven_seg_pkg;

  // Active-low segment patterns, bit order g,f,e,d,c,b,a
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Within a digit slot: anti-ghosting blank interval, then the digit itself
  typedef enum logic {
    SCAN_BLANK = 1'b0,
    SCAN_SHOW  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational nibble + decimal point to active-low cathode decode.
// HEX selects whether codes 10-15 render as A,b,C,d,E,F or stay dark.
module seg_hex_decoder
  import seven_seg_pkg::*;
#(
  parameter bit HEX = 1'b1
) (
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] cathode
);

  logic [6:0] seg;

  // Nibble to g..a pattern lookup
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = HEX ? SEG_A : SEG_BLANK;
      4'hB: seg = HEX ? SEG_B : SEG_BLANK;
      4'hC: seg = HEX ? SEG_C : SEG_BLANK;
      4'hD: seg = HEX ? SEG_D : SEG_BLANK;
      4'hE: seg = HEX ? SEG_E : SEG_BLANK;
      default: seg = HEX ? SEG_F : SEG_BLANK;
    endcase
  end

  assign cathode = {~dp, seg};

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit common-anode seven-segment scanner.
// New data is shadowed on load and committed only at the frame boundary,
// so a frame never mixes old and new digits. Pins are registered.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero
// digits (from the top digit downward, never digit 0).
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter bit HEX          = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load,
  output logic [N_DIGITS-1:0]   anode,
  output logic [7:0]            cathode,
  output logic                  frame_done
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam int DW = 4 * N_DIGITS;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_BLK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DW-1:0]       sh_dig_q, sh_dig_d;
  logic [N_DIGITS-1:0] sh_dp_q, sh_dp_d;
  logic                pend_q, pend_d;
  logic [DW-1:0]       act_dig_q, act_dig_d;
  logic [N_DIGITS-1:0] act_dp_q, act_dp_d;
  logic [N_DIGITS-1:0] anode_q, anode_d;
  logic [7:0]          cathode_q, cathode_d;
  logic                frame_done_q, frame_done_d;

  logic        boundary;
  logic        commit;
  scan_state_e scan_st;
  logic [3:0]  cur_nib;
  logic        cur_dp;
  logic [7:0]  dec_cat;

  // Last cycle of the last digit slot: the wrap back to digit 0
  assign boundary = (cnt_q == CNT_MAX) && (idx_q == IDX_MAX);
  assign commit   = boundary && (load || pend_q);
  assign scan_st  = (cnt_q < CNT_BLK) ? SCAN_BLANK : SCAN_SHOW;

  // Slot counter and digit index advance
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
  end

  // Shadow capture mid-frame, commit to the active register at the boundary;
  // a load landing on the boundary itself goes straight to active
  always_comb begin
    sh_dig_d  = sh_dig_q;
    sh_dp_d   = sh_dp_q;
    pend_d    = pend_q;
    act_dig_d = act_dig_q;
    act_dp_d  = act_dp_q;
    if (boundary) begin
      pend_d = 1'b0;
      if (load) begin
        act_dig_d = digits_in;
        act_dp_d  = dp_in;
      end else if (pend_q) begin
        act_dig_d = sh_dig_q;
        act_dp_d  = sh_dp_q;
      end
    end else if (load) begin
      sh_dig_d = digits_in;
      sh_dp_d  = dp_in;
      pend_d   = 1'b1;
    end
  end

  // frame_done is registered so it is high exactly during the boundary cycle
  assign frame_done_d = (cnt_d == CNT_MAX) && (idx_d == IDX_MAX);

  // Current digit selection feeding the single shared decoder
  assign cur_nib = act_dig_q[{idx_q, 2'b00} +: 4];
  assign cur_dp  = act_dp_q[idx_q];

  seg_hex_decoder #(.HEX(HEX)) u_dec (
    .nibble  (cur_nib),
    .dp      (cur_dp),
    .cathode (dec_cat)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] mask_q, mask_d;
  logic                run;

  // Leading-zero mask recomputed from the value being committed
  always_comb begin
    mask_d = mask_q;
    run    = 1'b1;
    if (commit) begin
      mask_d = '0;
      for (int i = N_DIGITS - 1; i >= 1; i--) begin
        run       = run & (act_dig_d[4*i +: 4] == 4'h0) & ~act_dp_d[i];
        mask_d[i] = run;
      end
    end
  end
`endif

  // Next pin values from the current scan position
  always_comb begin
    anode_d   = '1;
    cathode_d = 8'hFF;
    if (scan_st == SCAN_SHOW) begin
      anode_d[idx_q] = 1'b0;
      cathode_d      = dec_cat;
`ifdef LEADING_ZERO_BLANK_EN
      if (mask_q[idx_q]) cathode_d = 8'hFF;
`endif
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      sh_dig_q     <= '0;
      sh_dp_q      <= '0;
      pend_q       <= 1'b0;
      act_dig_q    <= '0;
      act_dp_q     <= '0;
      anode_q      <= '1;
      cathode_q    <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sh_dig_q     <= sh_dig_d;
      sh_dp_q      <= sh_dp_d;
      pend_q       <= pend_d;
      act_dig_q    <= act_dig_d;
      act_dp_q     <= act_dp_d;
      anode_q      <= anode_d;
      cathode_q    <= cathode_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Mask register, updated together with the active register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mask_q <= '0;
    else     mask_q <= mask_d;
  end
`endif

  assign anode      = anode_q;
  assign cathode    = cathode_q;
  assign frame_done = frame_done_q;

endmodule
